sram_like_arbiter: RTL and testbench

//  Shares one sram-like master port between the CPU instruction and data sram-like

---
 rtl/sram_like_arbiter_if.sv | 34 +++
 rtl/sram_like_arbiter.sv | 122 ++++++++++++
 tb/tb_sram_like_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if
//   One sram-like port: request fields travel master -> slave, the
//   response (read data and the two handshake strobes) slave -> master.
//   req      : request valid, held by the master until addr_ok
//   wr       : 1 = write, 0 = read
//   size     : 0 = byte, 1 = half, 2 = word
//   addr     : physical address
//   wdata    : write data
//   rdata    : read data, meaningful only while data_ok is high
//   addr_ok  : address accepted this cycle (req & addr_ok = handshake)
//   data_ok  : read data returned / write completed this cycle
// Handshake: a request is transferred on the rising edge where req and
// addr_ok are both high; the response is the single cycle where data_ok
// is high. The master must keep req and its fields stable until addr_ok.
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Merges the CPU instruction and data sram-like ports onto one
//   sram-like master port with a single transaction in flight. Data has
//   priority; a starvation counter lets a waiting instruction fetch win
//   after STARVE_LIMIT consecutive data grants (0 = strict data priority).
// Ports
//   aclk            clock, rising edge
//   aresetn         asynchronous active-low reset
//   inst_port       instruction-side sram-like slave port
//   data_port       data-side sram-like slave port
//   m_port          merged sram-like master port toward the bridge
//   dbg_state       current FSM state (0 IDLE, 1 WAIT_I, 2 WAIT_D)
//   dbg_starve_cnt  current starvation count, zero-extended
module sram_like_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  sram_like_arbiter_if.slave        inst_port,
  sram_like_arbiter_if.slave        data_port,
  sram_like_arbiter_if.master       m_port,
  output logic [1:0]                dbg_state,
  output logic [31:0]               dbg_starve_cnt
);

  localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam bit STARVE_EN = (STARVE_LIMIT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             starve_hit;
  logic             gnt_d;
  logic             gnt_i;
  logic             gnt_any;

  // Read data is broadcast; consumers qualify it with their own data_ok.
  assign inst_port.rdata = m_port.rdata;
  assign data_port.rdata = m_port.rdata;

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = 32'(cnt_q);

  // Grants exist only in IDLE and outside reset, so m_req and every
  // addr_ok fall out low during reset without extra gating downstream.
  always_comb begin
    starve_hit = STARVE_EN && inst_port.req && (cnt_q == CNT_MAX);
    gnt_d      = aresetn && (state_q == IDLE) && data_port.req && !starve_hit;
    gnt_i      = aresetn && (state_q == IDLE) && inst_port.req && !gnt_d;
    gnt_any    = gnt_d || gnt_i;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    m_port.req        = gnt_any;
    m_port.wr         = 1'b0;
    m_port.size       = 2'd0;
    m_port.addr       = 32'd0;
    m_port.wdata      = 32'd0;
    inst_port.addr_ok = gnt_i && m_port.addr_ok;
    data_port.addr_ok = gnt_d && m_port.addr_ok;
    inst_port.data_ok = 1'b0;
    data_port.data_ok = 1'b0;

    if (gnt_d) begin
      m_port.wr    = data_port.wr;
      m_port.size  = data_port.size;
      m_port.addr  = data_port.addr;
      m_port.wdata = data_port.wdata;
    end else if (gnt_i) begin
      m_port.wr    = inst_port.wr;
      m_port.size  = inst_port.size;
      m_port.addr  = inst_port.addr;
      m_port.wdata = inst_port.wdata;
    end

    case (state_q)
      IDLE: begin
        // m_data_ok seen here belongs to no live transaction and is dropped.
        if (gnt_any && m_port.addr_ok) begin
          state_d = gnt_d ? WAIT_D : WAIT_I;
          if (gnt_d && inst_port.req) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
      end
      WAIT_I: begin
        if (m_port.data_ok) begin
          inst_port.data_ok = aresetn;
          state_d           = IDLE;
        end
      end
      WAIT_D: begin
        if (m_port.data_ok) begin
          data_port.data_ok = aresetn;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

  localparam int STARVE_LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  dbg_state;
  logic [31:0] dbg_starve_cnt;

  always #5 aclk = ~aclk;

  sram_like_arbiter_if inst_if ();
  sram_like_arbiter_if data_if ();
  sram_like_arbiter_if m_if ();

  sram_like_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .inst_port      (inst_if.slave),
    .data_port      (data_if.slave),
    .m_port         (m_if.master),
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  // Reference model: number of data grants in a row taken while an
  // instruction request was waiting.
  int mdl_starve = 0;

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd2;
    inst_if.addr = 32'd0; inst_if.wdata = 32'd0;
    data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd2;
    data_if.addr = 32'd0; data_if.wdata = 32'd0;
    m_if.rdata = 32'd0; m_if.addr_ok = 1'b0; m_if.data_ok = 1'b0;
  endtask

  task automatic set_inst(input logic [31:0] addr);
    inst_if.req = 1'b1; inst_if.wr = 1'b0; inst_if.size = 2'd2;
    inst_if.addr = addr; inst_if.wdata = $urandom;
  endtask

  task automatic set_data(input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    data_if.req = 1'b1; data_if.wr = wr; data_if.size = size;
    data_if.addr = addr; data_if.wdata = wdata;
  endtask

  // Runs one full transaction from IDLE (called at posedge+1 with the
  // requests already driven). Predicts the winner from the model, holds
  // m_addr_ok low for aok_delay cycles, returns data lat cycles after
  // acceptance, and reports the winner (1 inst, 2 data).
  task automatic run_txn(input int aok_delay, input int lat,
                         input logic [31:0] rd, output int win);
    logic [67:0] exp_bus;
    logic [67:0] act_bus;
    bit inst_r, data_r;
    inst_r = inst_if.req;
    data_r = data_if.req;
    if (data_r && !(inst_r && STARVE_LIMIT != 0 && mdl_starve == STARVE_LIMIT)) win = 2;
    else if (inst_r) win = 1;
    else win = 0;
    if (win == 2) exp_bus = {1'b1, data_if.wr, data_if.size, data_if.addr, data_if.wdata};
    else if (win == 1) exp_bus = {1'b1, inst_if.wr, inst_if.size, inst_if.addr, inst_if.wdata};
    else exp_bus = '0;

    m_if.addr_ok = 1'b0;
    for (int d = 0; d < aok_delay; d++) begin
      @(negedge aclk);
      act_bus = {m_if.req, m_if.wr, m_if.size, m_if.addr, m_if.wdata};
      n_vec++;
      if (act_bus !== exp_bus) begin
        n_err++;
        $display("FAIL stall_bus: got %h expected %h", act_bus, exp_bus);
      end
      n_vec++;
      if ({inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok} !== 4'b0000) begin
        n_err++;
        $display("FAIL stall_oks: got %b expected 0000",
                 {inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok});
      end
      @(posedge aclk); #1;
    end

    m_if.addr_ok = 1'b1;
    @(negedge aclk);
    act_bus = {m_if.req, m_if.wr, m_if.size, m_if.addr, m_if.wdata};
    n_vec++;
    if (act_bus !== exp_bus) begin
      n_err++;
      $display("FAIL grant_bus: got %h expected %h", act_bus, exp_bus);
    end
    n_vec++;
    if ({inst_if.addr_ok, data_if.addr_ok} !== {win == 1, win == 2}) begin
      n_err++;
      $display("FAIL grant_addr_ok: got %b expected %b",
               {inst_if.addr_ok, data_if.addr_ok}, {win == 1, win == 2});
    end
    n_vec++;
    if (dbg_starve_cnt !== 32'(mdl_starve)) begin
      n_err++;
      $display("FAIL starve_cnt: got %0d expected %0d", dbg_starve_cnt, mdl_starve);
    end
    @(posedge aclk); #1;
    m_if.addr_ok = 1'b0;

    if (win == 2 && inst_r) mdl_starve = (mdl_starve < STARVE_LIMIT) ? mdl_starve + 1 : STARVE_LIMIT;
    else mdl_starve = 0;
    if (win == 1) inst_if.req = 1'b0;
    if (win == 2) data_if.req = 1'b0;

    for (int l = 1; l < lat; l++) begin
      @(negedge aclk);
      n_vec++;
      if ({m_if.req, inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok} !== 5'b0) begin
        n_err++;
        $display("FAIL wait_quiet: got %b expected 00000",
                 {m_if.req, inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok});
      end
      @(posedge aclk); #1;
    end

    m_if.rdata   = rd;
    m_if.data_ok = 1'b1;
    @(negedge aclk);
    n_vec++;
    if ({inst_if.data_ok, data_if.data_ok} !== {win == 1, win == 2}) begin
      n_err++;
      $display("FAIL resp_data_ok: got %b expected %b",
               {inst_if.data_ok, data_if.data_ok}, {win == 1, win == 2});
    end
    n_vec++;
    if ((win == 1 ? inst_if.rdata : data_if.rdata) !== rd) begin
      n_err++;
      $display("FAIL resp_rdata: got %h expected %h",
               (win == 1 ? inst_if.rdata : data_if.rdata), rd);
    end
    @(posedge aclk); #1;
    m_if.data_ok = 1'b0;
    m_if.rdata   = $urandom;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    aresetn = 1'b0;
    set_inst(32'hBFC0_0000);
    set_data(1'b0, 2'd2, 32'h0000_1000, 32'd0);
    m_if.addr_ok = 1'b1;
    m_if.data_ok = 1'b1;
    @(negedge aclk);
    n_vec++;
    if ({m_if.req, inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {m_if.req, inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok});
    end
    n_vec++;
    if (dbg_starve_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d expected 0", dbg_starve_cnt);
    end
    clear_inputs();
    @(posedge aclk); #1;
    aresetn = 1'b1;
    mdl_starve = 0;
    @(posedge aclk); #1;
  endtask

  task automatic test_inst_read();
    int win;
    set_inst(32'hBFC0_0000);
    run_txn(0, 3, 32'h3C08_BFAF, win);
    n_vec++;
    if (win !== 1) begin
      n_err++;
      $display("FAIL inst_read_winner: got %0d expected 1", win);
    end
    @(negedge aclk);
    n_vec++;
    if ({inst_if.data_ok, data_if.data_ok} !== 2'b00) begin
      n_err++;
      $display("FAIL inst_read_single_pulse: got %b expected 00", {inst_if.data_ok, data_if.data_ok});
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_priority();
    int win;
    set_inst(32'hBFC0_0010);
    set_data(1'b1, 2'd2, 32'h0000_2000, 32'hDEAD_BEEF);
    run_txn(0, 2, 32'h1111_2222, win);
    n_vec++;
    if (win !== 2) begin
      n_err++;
      $display("FAIL priority_first: got %0d expected 2", win);
    end
    run_txn(0, 1, 32'h3333_4444, win);
    n_vec++;
    if (win !== 1) begin
      n_err++;
      $display("FAIL priority_second: got %0d expected 1", win);
    end
  endtask

  task automatic test_starvation();
    int win;
    for (int k = 0; k < 10; k++) begin
      set_inst($urandom);
      set_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom);
      run_txn($urandom_range(0, 1), $urandom_range(1, 3), $urandom, win);
      n_vec++;
      if (win !== ((k % 5 == 4) ? 1 : 2)) begin
        n_err++;
        $display("FAIL starve_grant_%0d: got %0d expected %0d", k, win, (k % 5 == 4) ? 1 : 2);
      end
      if (k == 4) begin
        n_vec++;
        if (dbg_starve_cnt !== 32'd0) begin
          n_err++;
          $display("FAIL starve_cnt_cleared: got %0d expected 0", dbg_starve_cnt);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_write();
    int win;
    set_data(1'b1, 2'd1, 32'h1FAF_0002, 32'h0000_ABCD);
    run_txn(0, 2, 32'h0, win);
    n_vec++;
    if (win !== 2) begin
      n_err++;
      $display("FAIL write_winner: got %0d expected 2", win);
    end
  endtask

  task automatic test_addr_stall();
    int win;
    set_data(1'b0, 2'd2, 32'h0000_3000, 32'h0);
    run_txn(5, 2, 32'h5555_AAAA, win);
    n_vec++;
    if (win !== 2) begin
      n_err++;
      $display("FAIL stall_winner: got %0d expected 2", win);
    end
  endtask

  task automatic test_random();
    int win;
    for (int t = 0; t < 30; t++) begin
      if (!inst_if.req && $urandom_range(0, 1) == 1) set_inst($urandom);
      if (!data_if.req && $urandom_range(0, 2) != 0)
        set_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom);
      if (!inst_if.req && !data_if.req) set_inst($urandom);
      run_txn($urandom_range(0, 2), $urandom_range(1, 3), $urandom, win);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    int win;
    set_data(1'b0, 2'd2, 32'h0000_4000, 32'h0);
    m_if.addr_ok = 1'b1;
    @(posedge aclk); #1;   // accepted, DUT now waits for data
    m_if.addr_ok = 1'b0;
    data_if.req  = 1'b1;
    set_inst(32'hBFC0_0020);
    m_if.addr_ok = 1'b1;
    aresetn      = 1'b0;
    @(negedge aclk);
    n_vec++;
    if ({m_if.req, inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok} !== 5'b0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got %b expected 00000",
               {m_if.req, inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok});
    end
    clear_inputs();
    @(posedge aclk); #1;
    aresetn    = 1'b1;
    mdl_starve = 0;
    m_if.data_ok = 1'b1;   // stray response for the dropped transaction
    m_if.rdata   = 32'hBAD0_BAD0;
    @(negedge aclk);
    n_vec++;
    if ({inst_if.data_ok, data_if.data_ok} !== 2'b00) begin
      n_err++;
      $display("FAIL stray_data_ok: got %b expected 00", {inst_if.data_ok, data_if.data_ok});
    end
    @(posedge aclk); #1;
    m_if.data_ok = 1'b0;
    set_data(1'b0, 2'd2, 32'h0000_5000, 32'h0);
    run_txn(1, 2, 32'h7777_8888, win);
    n_vec++;
    if (win !== 2) begin
      n_err++;
      $display("FAIL after_reset_winner: got %0d expected 2", win);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_inputs();
    test_reset();
    test_inst_read();
    test_priority();
    test_starvation();
    test_write();
    test_addr_stall();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
